// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, the slave FSM state type and a byte-merge helper.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'd0,
    HSIZE_HALF = 3'd1,
    HSIZE_WORD = 3'd2
  } hsize_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // IDLE also covers a zero-wait data phase completing this cycle.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } slv_state_e;

  // Replace the enabled bytes of old_w with the matching bytes of new_w.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_w;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/ahb_byte_lane_dec.sv
// Little-endian byte-lane decode of {HSIZE, HADDR[1:0]} with alignment and size checks.
module ahb_byte_lane_dec
  import ahb_pkg::*;
(
  input  logic [2:0] hsize_i,
  input  logic [1:0] addr_lo_i,
  output logic [3:0] be_o,
  output logic       misalign_o,
  output logic       bad_size_o
);

  // Lane enables are zero for any access that cannot be performed.
  always_comb begin
    be_o       = 4'b0000;
    misalign_o = 1'b0;
    bad_size_o = 1'b0;
    case (hsize_i)
      HSIZE_BYTE: be_o = 4'b0001 << addr_lo_i;
      HSIZE_HALF: begin
        misalign_o = addr_lo_i[0];
        if (!addr_lo_i[0]) be_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
      end
      HSIZE_WORD: begin
        misalign_o = |addr_lo_i;
        if (addr_lo_i == 2'b00) be_o = 4'b1111;
      end
      default: bad_size_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/ahb_lite_mem_slave.sv
// AHB-Lite subordinate backed by a word-addressed RAM with optional wait states
// and the two-cycle ERROR response for out-of-window, oversized or misaligned transfers.
//
// Handshake: an address phase is taken when HSEL & HREADY & HTRANS[1] while the
// slave is able to accept (IDLE or ERR2). The data phase ends on the cycle the
// slave drives HREADYOUT=1; writes commit at that closing edge, reads present
// HRDATA during that cycle.
module ahb_lite_mem_slave
  import ahb_pkg::*;
#(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter int                MEM_WORDS   = 256,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int                WAIT_STATES = 0
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              HSEL,
  input  logic [ADDR_W-1:0] HADDR,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [2:0]        HBURST,
  input  logic [6:0]        HPROT,
  input  logic [1:0]        HTRANS,
  input  logic              HMASTLOCK,
  input  logic [DATA_W-1:0] HWDATA,
  input  logic              HREADY,
  output logic              HREADYOUT,
  output logic              HRESP,
  output logic [DATA_W-1:0] HRDATA,
  output logic [1:0]        dbg_state_o
);

  localparam int              IDX_W     = $clog2(MEM_WORDS);
  localparam logic [ADDR_W:0] WIN_BYTES = (ADDR_W+1)'(4 * MEM_WORDS);

  logic [DATA_W-1:0] mem_q [MEM_WORDS];

  slv_state_e        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              pend_q, pend_d;
  logic              wr_q, wr_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [1:0]        lo_q, lo_d;
  logic [2:0]        size_q, size_d;
  logic [DATA_W-1:0] hrdata_q, hrdata_d;
  logic              hreadyout_q, hreadyout_d;
  logic              hresp_q, hresp_d;

  // Burst type, protection and lock do not affect a single-beat RAM.
  logic unused_sig;
  assign unused_sig = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0]};

  // Address decode of the incoming address phase.
  logic [ADDR_W-1:0] off;
  logic              in_win;
  logic [3:0]        req_be;
  logic              req_misalign, req_bad_size;
  logic              accept, legal;

  assign off    = HADDR - BASE_ADDR;
  assign in_win = (HADDR >= BASE_ADDR) && ({1'b0, off} < WIN_BYTES);
  assign accept = HSEL & HREADY & HTRANS[1];
  assign legal  = in_win & ~req_misalign & ~req_bad_size;

  ahb_byte_lane_dec u_req_dec (
    .hsize_i    (HSIZE),
    .addr_lo_i  (HADDR[1:0]),
    .be_o       (req_be),
    .misalign_o (req_misalign),
    .bad_size_o (req_bad_size)
  );

  // Lane enables of the registered (data-phase) transfer; drives both the RAM
  // write and the forwarding merge into a same-edge read capture.
  logic [3:0] wr_be;
  logic       wr_misalign, wr_bad_size;

  ahb_byte_lane_dec u_wr_dec (
    .hsize_i    (size_q),
    .addr_lo_i  (lo_q),
    .be_o       (wr_be),
    .misalign_o (wr_misalign),
    .bad_size_o (wr_bad_size)
  );

  logic unused_dec;
  assign unused_dec = wr_misalign ^ wr_bad_size ^ (^req_be);

  // A write commits on the edge closing a zero-wait OKAY data cycle.
  logic commit_wr;
  assign commit_wr = pend_q & wr_q & (state_q == ST_IDLE);

  // Read capture source: the live address when capturing at accept, the
  // registered one when capturing at the end of the wait states.
  logic [IDX_W-1:0]  cap_idx;
  logic [DATA_W-1:0] cap_data;

  assign cap_idx = (state_q == ST_WAIT) ? idx_q : off[IDX_W+1:2];

  // RAM word for the read, with bytes of a same-edge write to that word forwarded.
  always_comb begin
    cap_data = mem_q[cap_idx];
    if (commit_wr && (idx_q == cap_idx)) cap_data = merge_bytes(cap_data, HWDATA, wr_be);
  end

  // Next-state logic for the data-phase FSM and its registered outputs.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pend_d   = pend_q;
    wr_d     = wr_q;
    idx_d    = idx_q;
    lo_d     = lo_q;
    size_d   = size_q;
    hrdata_d = hrdata_q;
    case (state_q)
      ST_IDLE, ST_ERR2: begin
        state_d = ST_IDLE;
        pend_d  = 1'b0;
        if (accept) begin
          if (legal) begin
            pend_d = 1'b1;
            wr_d   = HWRITE;
            idx_d  = off[IDX_W+1:2];
            lo_d   = HADDR[1:0];
            size_d = HSIZE;
            if (WAIT_STATES > 0) begin
              state_d = ST_WAIT;
              cnt_d   = 4'(WAIT_STATES - 1);
            end else if (!HWRITE) begin
              hrdata_d = cap_data;
            end
          end else begin
            state_d = ST_ERR1;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_IDLE;
          if (!wr_q) hrdata_d = cap_data;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase
    hreadyout_d = (state_d == ST_IDLE) || (state_d == ST_ERR2);
    hresp_d     = ((state_d == ST_ERR1) || (state_d == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
  end

  // FSM and pending-transfer registers; reset abandons any transfer in flight.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      pend_q      <= 1'b0;
      wr_q        <= 1'b0;
      idx_q       <= '0;
      lo_q        <= 2'b00;
      size_q      <= 3'd0;
      hrdata_q    <= '0;
      hreadyout_q <= 1'b1;
      hresp_q     <= HRESP_OKAY;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      wr_q        <= wr_d;
      idx_q       <= idx_d;
      lo_q        <= lo_d;
      size_q      <= size_d;
      hrdata_q    <= hrdata_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
    end
  end

  // RAM byte writes; contents survive reset but a write under reset is dropped.
  always_ff @(posedge HCLK) begin
    if (HRESETn && commit_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) mem_q[idx_q][8*i +: 8] <= HWDATA[8*i +: 8];
      end
    end
  end

  assign HREADYOUT   = hreadyout_q;
  assign HRESP       = hresp_q;
  assign HRDATA      = hrdata_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ahb_lite_mem_slave.sv
// Bench for ahb_lite_mem_slave: one zero-wait instance and one three-wait instance
// share a bus; a pipelined master walks directed transfer lists while a byte-level
// memory model predicts every data-phase cycle.
module tb_ahb_lite_mem_slave;

  // ---------------- clock / reset ----------------
  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;
  always #5 HCLK = ~HCLK;

  logic        HSEL = 1'b0, HWRITE = 1'b0, HMASTLOCK = 1'b0;
  logic [31:0] HADDR = '0, HWDATA = '0;
  logic [2:0]  HSIZE = '0, HBURST = '0;
  logic [6:0]  HPROT = '0;
  logic [1:0]  HTRANS = '0;
  logic        dsel = 1'b0;      // 0: zero-wait instance, 1: three-wait instance
  logic        force_lo = 1'b0;  // another slave holding the bus
  logic        ro0, rs0, ro1, rs1;
  logic [31:0] rd0, rd1;
  logic [1:0]  st0, st1;
  logic        hready_bus;

  assign hready_bus = force_lo ? 1'b0 : (dsel ? ro1 : ro0);

  ahb_lite_mem_slave #(.WAIT_STATES(0)) dut0 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL & ~dsel), .HADDR(HADDR), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HTRANS(HTRANS), .HMASTLOCK(HMASTLOCK),
    .HWDATA(HWDATA), .HREADY(hready_bus), .HREADYOUT(ro0), .HRESP(rs0), .HRDATA(rd0),
    .dbg_state_o(st0)
  );

  ahb_lite_mem_slave #(.WAIT_STATES(3)) dut1 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL & dsel), .HADDR(HADDR), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HTRANS(HTRANS), .HMASTLOCK(HMASTLOCK),
    .HWDATA(HWDATA), .HREADY(hready_bus), .HREADYOUT(ro1), .HRESP(rs1), .HRDATA(rd1),
    .dbg_state_o(st1)
  );

  // ---------------- scoreboard counters ----------------
  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] mm [2][1024];

  function automatic bit legal(input logic [31:0] a, input logic [2:0] s);
    if (a >= 32'd1024) return 1'b0;
    if (s > 3'd2) return 1'b0;
    if (s == 3'd1 && a[0]) return 1'b0;
    if (s == 3'd2 && a[1:0] != 2'b00) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] mword(input int d, input logic [31:0] a);
    int b;
    b = int'(a) & ~3;
    return {mm[d][b+3], mm[d][b+2], mm[d][b+1], mm[d][b]};
  endfunction

  task automatic mwrite(input int d, input logic [31:0] a, input logic [2:0] s, input logic [31:0] wd);
    int ai;
    for (int i = 0; i < (1 << s); i++) begin
      ai = int'(a) + i;
      mm[d][ai] = wd[8*(ai % 4) +: 8];
    end
  endtask

  // ---------------- stimulus lists and driver ----------------
  typedef struct {
    bit          xfer;
    bit          wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    int          stall;
  } item_t;

  item_t seq_q[$];
  item_t ap, dp_it;
  bit    ap_v = 1'b0, dp_v = 1'b0;
  int    dp_k = 0;
  int    stall_cnt = 0;
  bit    rdy_seen = 1'b1;
  bit    mon_en = 1'b0;

  task automatic W(input logic [31:0] a, input logic [2:0] s, input logic [31:0] d);
    item_t it;
    it = '{xfer: 1'b1, wr: 1'b1, addr: a, size: s, wdata: d, stall: 0};
    seq_q.push_back(it);
  endtask

  task automatic R(input logic [31:0] a, input logic [2:0] s, input int stall);
    item_t it;
    it = '{xfer: 1'b1, wr: 1'b0, addr: a, size: s, wdata: 32'h0, stall: stall};
    seq_q.push_back(it);
  endtask

  task automatic IDL();
    item_t it;
    it = '{xfer: 1'b0, wr: 1'b0, addr: 32'h0, size: 3'd0, wdata: 32'h0, stall: 0};
    seq_q.push_back(it);
  endtask

  task automatic load_ap();
    if (seq_q.size() > 0) begin
      ap     = seq_q.pop_front();
      ap_v   = 1'b1;
      HSEL   = 1'b1;
      HTRANS = ap.xfer ? 2'b10 : 2'b00;
      HADDR  = ap.addr;
      HWRITE = ap.wr;
      HSIZE  = ap.size;
      if (ap.stall > 0) begin
        force_lo  = 1'b1;
        stall_cnt = ap.stall;
      end
    end else begin
      ap_v   = 1'b0;
      HSEL   = 1'b0;
      HTRANS = 2'b00;
      HADDR  = 32'h0;
      HWRITE = 1'b0;
      HSIZE  = 3'd0;
    end
  endtask

  // Pipelined master: the address phase moves to the data phase whenever the
  // bus HREADY seen before the edge was high.
  task automatic run_seq();
    int guard;
    guard = 0;
    @(posedge HCLK); #1;
    load_ap();
    while ((ap_v || dp_v) && guard < 400) begin
      @(posedge HCLK); #1;
      guard++;
      if (stall_cnt > 0) begin
        stall_cnt--;
        if (stall_cnt == 0) force_lo = 1'b0;
      end
      if (rdy_seen) begin
        dp_v   = ap_v && ap.xfer;
        dp_it  = ap;
        dp_k   = 0;
        HWDATA = (ap_v && ap.xfer && ap.wr) ? ap.wdata : $urandom();
        load_ap();
      end
    end
    if (guard >= 400) begin
      n_chk++;
      $display("FAIL seq_timeout: got %0d cycles, expected fewer than 400", guard);
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge HCLK) begin : cmp
    logic        r, e;
    logic [31:0] d;
    int          di, ws;
    rdy_seen = hready_bus;
    if (mon_en) begin
      di = dsel ? 1 : 0;
      ws = dsel ? 3 : 0;
      r  = dsel ? ro1 : ro0;
      e  = dsel ? rs1 : rs0;
      d  = dsel ? rd1 : rd0;
      if (!dp_v) begin
        chk("idle_ready", {31'b0, r}, 32'd1);
        chk("idle_resp", {31'b0, e}, 32'd0);
      end else if (legal(dp_it.addr, dp_it.size)) begin
        if (dp_k < ws) begin
          chk("wait_ready", {31'b0, r}, 32'd0);
          chk("wait_resp", {31'b0, e}, 32'd0);
        end else begin
          chk("done_ready", {31'b0, r}, 32'd1);
          chk("done_resp", {31'b0, e}, 32'd0);
          if (dp_it.wr) mwrite(di, dp_it.addr, dp_it.size, dp_it.wdata);
          else chk("rdata", d, mword(di, dp_it.addr));
        end
      end else begin
        if (dp_k == 0) begin
          chk("err1_ready", {31'b0, r}, 32'd0);
          chk("err1_resp", {31'b0, e}, 32'd1);
        end else begin
          chk("err2_ready", {31'b0, r}, 32'd1);
          chk("err2_resp", {31'b0, e}, 32'd1);
        end
      end
      if (dp_v) dp_k++;
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- directed test sequence ----------------
  initial begin
    HRESETn = 1'b0;
    repeat (3) @(posedge HCLK);
    @(negedge HCLK);
    chk("rst_ready0", {31'b0, ro0}, 32'd1);
    chk("rst_resp0", {31'b0, rs0}, 32'd0);
    chk("rst_rdata0", rd0, 32'h0);
    chk("rst_ready1", {31'b0, ro1}, 32'd1);
    chk("rst_resp1", {31'b0, rs1}, 32'd0);
    chk("rst_rdata1", rd1, 32'h0);
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
    mon_en  = 1'b1;

    // Zero-wait: word write/read, byte and halfword lanes, W->R forwarding.
    dsel = 1'b0;
    W(32'h10, 3'd2, 32'hDEADBEEF); R(32'h10, 3'd2, 0);
    W(32'h20, 3'd2, 32'h77665544); W(32'h21, 3'd0, 32'hCCDDAAEE);
    W(32'h22, 3'd1, 32'h1234FFEE); R(32'h20, 3'd2, 0);
    W(32'h40, 3'd2, 32'h5A5A5A5A); R(32'h40, 3'd2, 0);
    run_seq();
    chk("pin_fwd_rdata", rd0, 32'h5A5A5A5A);
    chk("pin_model_0x20", mword(0, 32'h20), 32'h1234AA44);

    // Zero-wait: illegal transfers leave RAM untouched.
    W(32'h00, 3'd2, 32'h01020304); IDL(); R(32'h12, 3'd1, 0);
    R(32'h03, 3'd2, 0); W(32'h400, 3'd2, 32'hFFFFFFFF);
    W(32'h11, 3'd1, 32'hFFFFFFFF); W(32'h10, 3'd3, 32'hFFFFFFFF);
    R(32'h10, 3'd2, 0); R(32'h00, 3'd2, 0);
    run_seq();
    chk("pin_after_err_rdata", rd0, 32'h01020304);
    chk("pin_model_0x10", mword(0, 32'h10), 32'hDEADBEEF);

    // Three-wait: write/read, HREADY held low by another slave, error path.
    dsel = 1'b1;
    W(32'h10, 3'd2, 32'hCAFEF00D); R(32'h10, 3'd2, 0); IDL();
    R(32'h10, 3'd2, 2); R(32'h404, 3'd2, 0); R(32'h10, 3'd2, 0);
    run_seq();
    chk("pin_ws3_rdata", rd1, 32'hCAFEF00D);

    // Reset during a wait cycle of a write.
    mon_en = 1'b0;
    @(posedge HCLK); #1;
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h10; HWRITE = 1'b1; HSIZE = 3'd2;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = 32'h0BAD0BAD;
    @(negedge HCLK);
    chk("rst_mid_wait_ready", {31'b0, ro1}, 32'd0);
    @(posedge HCLK); #1;
    HRESETn = 1'b0;
    @(posedge HCLK); #1;
    @(negedge HCLK);
    chk("rst_mid_ready", {31'b0, ro1}, 32'd1);
    chk("rst_mid_resp", {31'b0, rs1}, 32'd0);
    chk("rst_mid_rdata1", rd1, 32'h0);
    chk("rst_mid_rdata0", rd0, 32'h0);
    chk("rst_mid_state", {30'b0, st1}, 32'd0);
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
    mon_en  = 1'b1;
    R(32'h10, 3'd2, 0);
    run_seq();
    chk("pin_rst_no_commit", rd1, 32'hCAFEF00D);

    repeat (2) @(posedge HCLK);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ahb_lite_mem_slave.md
Name: ahb_lite_mem_slave

Overview:
- AHB-Lite subordinate that sits directly downstream of the ahb interface: it consumes the HADDR/HTRANS/HWDATA traffic and drives HREADYOUT/HRESP/HRDATA back.
- Backs a word-addressed internal RAM, with a configurable number of wait states.
- Returns the two-cycle ERROR response for illegal transfers.
- Serves as the DUT/loopback target for the ahb agent in the noc environment.

Parameters:
- ADDR_W, 32, HADDR width.
- DATA_W, 32, HWDATA/HRDATA width; fixed at 32 for this block.
- MEM_WORDS, 256, RAM depth in 32-bit words (power of two).
- BASE_ADDR, 32'h0000_0000, first byte address decoded; window is BASE_ADDR .. BASE_ADDR+4*MEM_WORDS-1.
- WAIT_STATES, 0, number of HREADYOUT=0 cycles inserted in every OKAY data phase (0..15).

Ports:
- HCLK  in  1  clock, all logic on posedge.
- HRESETn  in  1  reset; synchronous, active-low.
- HSEL  in  1  slave select.
- HADDR  in  ADDR_W  byte address.
- HWRITE  in  1  1=write.
- HSIZE  in  3  transfer size.
- HBURST  in  3  burst type; ignored (each beat handled individually).
- HPROT  in  7  protection; ignored.
- HTRANS  in  2  IDLE/BUSY/NONSEQ/SEQ.
- HMASTLOCK  in  1  ignored.
- HWDATA  in  DATA_W  write data (data phase).
- HREADY  in  1  bus-level ready (from the interconnect mux).
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  0=OKAY, 1=ERROR.
- HRDATA  out  DATA_W  read data.

Behaviour:
- Reset (HRESETn=0 at posedge): HREADYOUT=1, HRESP=0, HRDATA=0, FSM=IDLE, wait counter=0, pending-phase registers cleared. RAM contents are not reset.
- Address phase accepted when HSEL & HREADY & HTRANS[1]=1 (NONSEQ/SEQ). The slave registers HADDR, HWRITE and HSIZE.
- IDLE/BUSY with HSEL, or HSEL=0: no access; the next cycle is zero-wait OKAY.
- Illegal transfer, which takes the ERROR path:
  - address outside the window;
  - HSIZE>2;
  - misalignment: halfword with HADDR[0]=1, or word with HADDR[1:0]!=0.
- FSM states: IDLE, WAIT, ERR1, ERR2.
- IDLE → WAIT on a legal accept with WAIT_STATES>0; the counter loads WAIT_STATES-1.
- IDLE stays IDLE on a legal accept with WAIT_STATES=0; the data phase completes the next cycle with HREADYOUT=1.
- WAIT: HREADYOUT=0, HRESP=0, counter decrements. At 0 → IDLE, and the next cycle has HREADYOUT=1.
- IDLE/WAIT-complete → ERR1 on an illegal accept.
- ERR1: HREADYOUT=0, HRESP=1; always → ERR2.
- ERR2: HREADYOUT=1, HRESP=1. New address-phase accepts are evaluated here as in IDLE.
- An errored transfer never modifies RAM; HRDATA is held.
- Write commit: at the edge ending the data phase (HREADYOUT=1 & HRESP=0). Byte lanes are decoded from the registered HSIZE and HADDR[1:0] (little-endian); only enabled bytes of HWDATA are written.
- Read capture: HRDATA is loaded at the edge entering the final data-phase cycle. That edge is the end of the address phase if WAIT_STATES=0, otherwise the end of the last WAIT cycle. HRDATA is held otherwise.
- Read forwarding: if a write commits on the same edge to the same word, the write's enabled bytes override the RAM bytes in the captured data. Back-to-back W→R to the same address must return the new data.
- HRDATA returns the full word; the master selects lanes.
- Throughput: with WAIT_STATES=0, one transfer per cycle, fully pipelined.
- HREADY low from another slave: no accept; state is held.
- Reset mid-transfer: abandon the transfer immediately and apply reset values. A partially completed write does not commit.

Decomposition:
- ahb_pkg holds:
  - htrans_e (IDLE=2'b00, BUSY=2'b01, NONSEQ=2'b10, SEQ=2'b11);
  - hsize_e (BYTE, HALF, WORD);
  - HRESP_OKAY / HRESP_ERROR constants;
  - the slave FSM enum.
- Sub-module ahb_byte_lane_dec: combinational {HSIZE, HADDR[1:0]} → 4-bit byte enable plus misalign flag. It is reused by the write path and the forwarding path.

Test Plan:
- WAIT_STATES=0: write word 32'hDEADBEEF @0x10, then read @0x10 → read data phase HREADYOUT=1, HRESP=0, HRDATA=32'hDEADBEEF; each transfer completes in 1 data cycle.
- Byte writes: 8'hAA @0x21, halfword 16'h1234 @0x22, then word read @0x20 → HRDATA[31:8]=24'h1234AA, with the low byte unchanged from its prior value.
- Back-to-back NONSEQ write 32'h5A5A5A5A @0x40 then immediate read @0x40 (pipelined) → HRDATA=32'h5A5A5A5A via forwarding.
- WAIT_STATES=3: read → exactly 3 cycles of HREADYOUT=0, then 1 cycle of HREADYOUT=1 with valid data.
- Word access @0x03, and separately an access @BASE_ADDR+4*MEM_WORDS → ERR1 (HREADYOUT=0, HRESP=1) then ERR2 (HREADYOUT=1, HRESP=1); a subsequent read shows RAM unchanged.
- Assert HRESETn=0 during a WAIT cycle of a write → the next cycle has HREADYOUT=1, HRESP=0, HRDATA=0; a later read of that address shows the old data.
